// File: rtl/tamagotchi_pkg.sv
// Shared pet state codes and timing helpers for the Tamagotchi blocks.
package tamagotchi_pkg;

    localparam int unsigned STATE_W    = 3;
    localparam int unsigned NUM_STATES = 6;

    localparam logic [STATE_W-1:0] FELIZ   = 3'd0;
    localparam logic [STATE_W-1:0] HAMBRE  = 3'd1;
    localparam logic [STATE_W-1:0] CANSADO = 3'd2;
    localparam logic [STATE_W-1:0] TRISTE  = 3'd3;
    localparam logic [STATE_W-1:0] ENFERMO = 3'd4;
    localparam logic [STATE_W-1:0] MUERTO  = 3'd5;

    function automatic int unsigned ms_to_cycles(input int unsigned frec, input int unsigned ms);
        return (frec / 1000) * ms;
    endfunction

    function automatic int unsigned s_to_cycles(input int unsigned frec, input int unsigned s);
        return frec * s;
    endfunction

    // Counter width for a terminal count n; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [STATE_W-1:0] next_state(input logic [STATE_W-1:0] s);
        return (s == MUERTO) ? FELIZ : s + STATE_W'(1);
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Synchronizes and debounces an active-low push-button; pulses once per press.
module button_debouncer
    import tamagotchi_pkg::*;
#(
    parameter int unsigned DEB_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);

    localparam int unsigned CNT_W = cnt_width(DEB_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        press_d = 1'b0;
        // Any cycle of agreement restarts the stability window.
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                press_d = level_q & ~sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/test_mode_sequencer.sv
// Test-mode override: steps a forced pet state on button presses or a hands-free timer.
module test_mode_sequencer
    import tamagotchi_pkg::*;
#(
    parameter int unsigned frec_fpga   = 50000000,
    parameter int unsigned debounce_ms = 20,
    parameter int unsigned auto_segs   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               test_enable,
    input  logic               btn_step,
    output logic               test_override,
    output logic [STATE_W-1:0] forced_state,
    output logic               step_pulse
);

    localparam int unsigned DEB_CYC  = ms_to_cycles(frec_fpga, debounce_ms);
    localparam int unsigned AUTO_CYC = s_to_cycles(frec_fpga, auto_segs);
    localparam bit          AUTO_EN  = (auto_segs != 0);
    localparam int unsigned AUTO_W   = cnt_width(AUTO_CYC);
    localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_EN ? AUTO_W'(AUTO_CYC - 1) : '0;

    logic               press;
    logic               te_q;
    logic               override_q, override_d;
    logic [STATE_W-1:0] state_q, state_d;
    logic [AUTO_W-1:0]  auto_q, auto_d;
    logic               pulse_q, pulse_d;
    logic               te_entry, te_exit, active, auto_hit, advance;

    button_debouncer #(
        .DEB_CYC (DEB_CYC)
    ) u_step_deb (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_step),
        .press   (press)
    );

    always_comb begin
        te_entry   = test_enable & ~te_q;
        te_exit    = ~test_enable & te_q;
        active     = test_enable & te_q;
        auto_hit   = AUTO_EN && (auto_q == AUTO_LAST);
        advance    = active & (press | auto_hit);

        override_d = override_q;
        state_d    = state_q;
        auto_d     = auto_q;
        pulse_d    = 1'b0;

        // Mode edges win over any coincident press, so a stale press never leaks in.
        if (te_entry) begin
            override_d = 1'b1;
            state_d    = FELIZ;
            auto_d     = '0;
        end else if (te_exit) begin
            override_d = 1'b0;
            state_d    = FELIZ;
            auto_d     = '0;
        end else if (advance) begin
            state_d    = next_state(state_q);
            pulse_d    = 1'b1;
            auto_d     = '0;
        end else if (active && AUTO_EN) begin
            auto_d     = auto_q + AUTO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            te_q       <= 1'b0;
            override_q <= 1'b0;
            state_q    <= FELIZ;
            auto_q     <= '0;
            pulse_q    <= 1'b0;
        end else begin
            te_q       <= test_enable;
            override_q <= override_d;
            state_q    <= state_d;
            auto_q     <= auto_d;
            pulse_q    <= pulse_d;
        end
    end

    assign test_override = override_q;
    assign forced_state  = state_q;
    assign step_pulse    = pulse_q;

endmodule

// File: tb/tb_test_mode_sequencer.sv
// Directed bench for test_mode_sequencer with DEB_CYC=4 and AUTO_CYC=2000.
module tb_test_mode_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       test_enable;
    logic       btn_step;
    logic       test_override;
    logic [2:0] forced_state;
    logic       step_pulse;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    test_mode_sequencer #(
        .frec_fpga   (1000),
        .debounce_ms (4),
        .auto_segs   (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .test_enable   (test_enable),
        .btn_step      (btn_step),
        .test_override (test_override),
        .forced_state  (forced_state),
        .step_pulse    (step_pulse)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input int exp);
        n_checks++;
        if (got === 32'(exp)) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_count(input int n, output int pulses);
        pulses = 0;
        repeat (n) begin
            tick();
            if (step_pulse === 1'b1) pulses++;
        end
    endtask

    // Raw press held from the current cycle t; the strobe must land in cycle t+7.
    task automatic press(input string tag, input int exp_state);
        int pre;
        btn_step = 1'b0;
        run_count(6, pre);
        check_eq({tag, "_early"}, 32'(pre), 0);
        tick();
        check_eq({tag, "_pulse"}, 32'(step_pulse), 1);
        check_eq({tag, "_state"}, 32'(forced_state), exp_state);
        tick();
        check_eq({tag, "_once"}, 32'(step_pulse), 0);
        btn_step = 1'b1;
        repeat (10) tick();
    endtask

    initial begin
        int p;
        rst         = 1'b1;
        test_enable = 1'b0;
        btn_step    = 1'b1;
        tick();
        tick();
        check_eq("rst_override", 32'(test_override), 0);
        check_eq("rst_state", 32'(forced_state), 0);
        check_eq("rst_pulse", 32'(step_pulse), 0);
        rst = 1'b0;
        tick();

        // 1: entry and exit latency
        test_enable = 1'b1;
        check_eq("entry_before_edge", 32'(test_override), 0);
        tick();
        check_eq("entry_override", 32'(test_override), 1);
        check_eq("entry_state", 32'(forced_state), 0);
        check_eq("entry_pulse", 32'(step_pulse), 0);
        tick();
        check_eq("entry_pulse2", 32'(step_pulse), 0);
        test_enable = 1'b0;
        tick();
        check_eq("exit_override", 32'(test_override), 0);
        check_eq("exit_state", 32'(forced_state), 0);

        // 2: manual presses wrap through all six states
        test_enable = 1'b1;
        tick();
        tick();
        press("press1", 1);
        press("press2", 2);
        press("press3", 3);
        press("press4", 4);
        press("press5", 5);
        press("press6", 0);

        // 3: bounce shorter than the debounce window is rejected
        p = 0;
        for (int i = 0; i < 40; i++) begin
            btn_step = ((i / 2) % 2) == 0 ? 1'b0 : 1'b1;
            tick();
            if (step_pulse === 1'b1) p++;
        end
        btn_step = 1'b1;
        begin
            int q;
            run_count(12, q);
            p += q;
        end
        check_eq("bounce_pulses", 32'(p), 0);
        check_eq("bounce_state", 32'(forced_state), 0);

        // 4: auto advance every 2000 cycles, restarted by a manual press
        test_enable = 1'b0;
        tick();
        test_enable = 1'b1;
        tick();
        run_count(1999, p);
        check_eq("auto1_early", 32'(p), 0);
        tick();
        check_eq("auto1_pulse", 32'(step_pulse), 1);
        check_eq("auto1_state", 32'(forced_state), 1);
        run_count(3999, p);
        check_eq("auto2_count", 32'(p), 1);
        tick();
        check_eq("auto3_pulse", 32'(step_pulse), 1);
        check_eq("auto3_state", 32'(forced_state), 3);
        run_count(1493, p);
        check_eq("auto_gap", 32'(p), 0);
        press("restart_press", 4);
        run_count(1988, p);
        check_eq("restart_early", 32'(p), 0);
        tick();
        check_eq("restart_pulse", 32'(step_pulse), 1);
        check_eq("restart_state", 32'(forced_state), 5);

        // 5a: press outside test mode is discarded
        test_enable = 1'b0;
        tick();
        btn_step = 1'b0;
        run_count(10, p);
        check_eq("off_press_pulses", 32'(p), 0);
        check_eq("off_press_override", 32'(test_override), 0);
        check_eq("off_press_state", 32'(forced_state), 0);
        test_enable = 1'b1;
        tick();
        check_eq("reentry_override", 32'(test_override), 1);
        check_eq("reentry_state", 32'(forced_state), 0);
        check_eq("reentry_pulse", 32'(step_pulse), 0);
        btn_step = 1'b1;
        run_count(12, p);
        check_eq("release_no_event", 32'(p), 0);

        // 5b: debounced press coincides with auto expiry
        test_enable = 1'b0;
        tick();
        test_enable = 1'b1;
        tick();
        run_count(1993, p);
        check_eq("align_gap", 32'(p), 0);
        press("align", 1);

        // 6: reset mid-operation, then entry re-occurs with test_enable still high
        press("pre_rst1", 2);
        press("pre_rst2", 3);
        press("pre_rst3", 4);
        run_count(500, p);
        check_eq("pre_rst_idle", 32'(p), 0);
        rst = 1'b1;
        tick();
        check_eq("midrst_override", 32'(test_override), 0);
        check_eq("midrst_state", 32'(forced_state), 0);
        check_eq("midrst_pulse", 32'(step_pulse), 0);
        rst = 1'b0;
        check_eq("post_rst_hold", 32'(test_override), 0);
        tick();
        check_eq("post_rst_override", 32'(test_override), 1);
        check_eq("post_rst_state", 32'(forced_state), 0);
        run_count(1999, p);
        check_eq("post_rst_early", 32'(p), 0);
        tick();
        check_eq("post_rst_auto", 32'(step_pulse), 1);
        check_eq("post_rst_auto_state", 32'(forced_state), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/test_mode_sequencer.md
Name: test_mode_sequencer

Overview:
- Consumer side of the Tamagotchi test-mode interface: takes the `test_enable` level produced by the long-press test toggle and, while it is high, drives forced pet states into the display/state logic.
- In test mode, each debounced press of the step button (active-low) advances a forced state code through the six pet states.
- With no press for `auto_segs` seconds, the code advances automatically so all displays can be checked hands-free.
- Outside test mode the override is released and the normal pet FSM owns the display.

Parameters:
- `frec_fpga`, 50000000, clock frequency in Hz.
- `debounce_ms`, 20, button stable time in ms; `DEB_CYC = (frec_fpga/1000)*debounce_ms`.
- `auto_segs`, 3, auto-advance period in s; `AUTO_CYC = frec_fpga*auto_segs`; 0 disables auto-advance.

Ports:
- `clk`  input  1  system clock.
- `rst`  input  1  synchronous, active-high reset.
- `test_enable`  input  1  test-mode level from the test toggle block; synchronous to `clk`.
- `btn_step`  input  1  raw step push-button, active-low (0 = pressed), asynchronous.
- `test_override`  output  1  high while forced states are valid.
- `forced_state`  output  3  forced pet state code, 0..5.
- `step_pulse`  output  1  one-cycle strobe on every advance, manual or auto.

Behaviour:
- Reset (sampled on `posedge clk` when `rst`=1):
  - `test_override`=0, `forced_state`=0, `step_pulse`=0.
  - Synchronizer flops and debounced level = 1 (released).
  - Debounce and auto counters = 0; registered `test_enable` copy = 0.
  - Reset mid-operation aborts everything identically.
- Input conditioning:
  - `btn_step` passes through a 2-flop synchronizer.
  - The debounced level flips only after the synchronized value has differed from it for `DEB_CYC` consecutive cycles.
  - Any cycle of agreement clears the debounce counter (bounce rejection).
- Press event: debounced level 1→0 transition. Release (0→1) generates no event.
- Mode tracking: `te_q` is the registered copy of `test_enable`.
  - Entry cycle: `test_enable`=1, `te_q`=0. On that edge: `test_override`←1, `forced_state`←0, auto counter←0, no `step_pulse`.
  - Exit cycle: `test_enable`=0, `te_q`=1. On that edge: `test_override`←0, `forced_state`←0, auto counter←0.
  - Latency from `test_enable` to `test_override` is 1 clock, both edges.
- Advance, only when `test_enable`=1 and `te_q`=1:
  - Triggered by a press event, or by the auto counter reaching `AUTO_CYC-1` (only when `auto_segs`≠0).
  - On the advance edge: `forced_state` ← (`forced_state`==5) ? 0 : `forced_state`+1; `step_pulse`←1 for exactly that cycle; auto counter←0.
  - Otherwise the auto counter increments by 1 each cycle while in test mode.
- Simultaneous events:
  - Press and auto expiry in the same cycle → a single advance of +1.
  - Press on the entry cycle → ignored; entry takes precedence.
  - Press on the exit cycle → ignored.
  - Presses while `test_enable`=0 → discarded, never queued.
- Latency: with raw `btn_step` held low from cycle t, `step_pulse` is high in cycle t+`DEB_CYC`+3. This covers 2 synchronizer cycles, `DEB_CYC` debounce cycles and 1 cycle to register the event.
- Widths:
  - Counters are sized with `$clog2` of their terminal count.
  - `forced_state` never takes the values 6 or 7.
- State codes: 0 FELIZ, 1 HAMBRE, 2 CANSADO, 3 TRISTE, 4 ENFERMO, 5 MUERTO.

Decomposition:
- Shared package `tamagotchi_pkg`:
  - State code constants (FELIZ..MUERTO) and `NUM_STATES`=6.
  - `STATE_W`=3.
  - A cycles-from-ms/seconds helper function shared with the other timing blocks.
- One natural sub-module: `button_debouncer`, holding the synchronizer, the debounce counter and the falling-edge pulse output.
  - Parameterised by `DEB_CYC`.
  - Reused for the other pet buttons.

Test Plan:
All scenarios use `frec_fpga`=1000, `debounce_ms`=4 (so `DEB_CYC`=4) and `auto_segs`=2 (so `AUTO_CYC`=2000).
1. Reset, then `test_enable` 0→1 → `test_override`=1 one cycle later, `forced_state`=0, no `step_pulse`. `test_enable` 1→0 → `test_override`=0 and `forced_state`=0 one cycle later.
2. Test mode on; hold `btn_step`=0 from cycle t → `step_pulse` high only in cycle t+7 and `forced_state`=1. Six presses total wrap the code 1,2,3,4,5,0.
3. Bounce `btn_step` 0/1 every 2 cycles for 40 cycles → no `step_pulse`, `forced_state` unchanged.
4. Test mode on, no presses → `step_pulse` every 2000 cycles; `forced_state` reaches 3 after 6000 cycles. A press at cycle 1500 restarts the count, so the next auto advance comes 2000 cycles after that press's pulse.
5. Press completes while `test_enable`=0, then enter test mode → `forced_state`=0 and no `step_pulse`. Align debounced press with auto expiry → `forced_state` advances by exactly 1.
6. Assert `rst` with `forced_state`=4 and the auto counter mid-count → next cycle all outputs 0. After `rst` is released with `test_enable` still high, the entry edge re-occurs and `test_override` returns to 1 one cycle later.
